// File: rtl/pong_game_control.sv
// Pong game-flow controller: serve countdown, rally, point scoring,
// game-over detection and start-button handling. Drives the enables and the
// recentre pulse for the paddle/ball datapath.
// Optional feature: define PONG_PAUSE_EN to add the pause_n button and the
// PAUSED state (code 5). Without it, code 5 is illegal and returns to IDLE.
module pong_game_control #(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_n,
`ifdef PONG_PAUSE_EN
  input  logic       pause_n,
`endif
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       paddle_en,
  output logic       ball_en,
  output logic       position_reset,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SERVE    = 3'd1;
  localparam logic [2:0] ST_PLAY     = 3'd2;
  localparam logic [2:0] ST_POINT    = 3'd3;
  localparam logic [2:0] ST_GAMEOVER = 3'd4;
`ifdef PONG_PAUSE_EN
  localparam logic [2:0] ST_PAUSED   = 3'd5;
`endif

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  logic [2:0] state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] score_left_q, score_left_d;
  logic [3:0] score_right_q, score_right_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_dir_q, serve_dir_d;
  logic       paddle_en_q, paddle_en_d;
  logic       ball_en_q, ball_en_d;
  logic       position_reset_q, position_reset_d;

  // Button synchronizers: two metastability flops plus one history flop
  // so a falling edge is seen after the second flop and acted on one edge later.
  logic [1:0] start_sync_q, start_sync_d;
  logic       start_prev_q, start_prev_d;
  logic       start_press;
`ifdef PONG_PAUSE_EN
  logic [1:0] pause_sync_q, pause_sync_d;
  logic       pause_prev_q, pause_prev_d;
  logic       pause_press;
`endif

  // Synchronizer shift and press (1->0) detection.
  always_comb begin
    start_sync_d = {start_sync_q[0], start_n};
    start_prev_d = start_sync_q[1];
    start_press  = start_prev_q & ~start_sync_q[1];
`ifdef PONG_PAUSE_EN
    pause_sync_d = {pause_sync_q[0], pause_n};
    pause_prev_d = pause_sync_q[1];
    pause_press  = pause_prev_q & ~pause_sync_q[1];
`endif
  end

  // Next-state, score and registered-output logic.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    winner_d      = winner_q;
    serve_dir_d   = serve_dir_q;

    case (state_q)
      ST_IDLE: begin
        score_left_d  = 4'd0;
        score_right_d = 4'd0;
        winner_d      = WIN_NONE;
        if (start_press) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt_q >= SERVE_LAST) state_d = ST_PLAY;
          else                           frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      ST_PLAY: begin
`ifdef PONG_PAUSE_EN
        if (pause_press) begin
          state_d = ST_PAUSED;
        end else
`endif
        if (miss_left && miss_right) begin
          // Simultaneous misses: nobody scores, replay the serve.
          state_d = ST_SERVE;
        end else if (miss_left) begin
          if (score_right_q < WIN) score_right_d = score_right_q + 4'd1;
          serve_dir_d = 1'b0;
          state_d     = ST_POINT;
        end else if (miss_right) begin
          if (score_left_q < WIN) score_left_d = score_left_q + 4'd1;
          serve_dir_d = 1'b1;
          state_d     = ST_POINT;
        end
      end
      ST_POINT: begin
        if (score_right_q == WIN) begin
          winner_d = WIN_RIGHT;
          state_d  = ST_GAMEOVER;
        end else if (score_left_q == WIN) begin
          winner_d = WIN_LEFT;
          state_d  = ST_GAMEOVER;
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_GAMEOVER: begin
        if (start_press) begin
          score_left_d  = 4'd0;
          score_right_d = 4'd0;
          winner_d      = WIN_NONE;
          state_d       = ST_SERVE;
        end
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSED: begin
        if (pause_press) state_d = ST_PLAY;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Every entry into SERVE restarts the countdown and recentres objects.
    position_reset_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    if (position_reset_d) frame_cnt_d = 8'd0;

    // Enables follow the next state so they change with the state register.
    paddle_en_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    ball_en_d   = (state_d == ST_PLAY);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      frame_cnt_q      <= 8'd0;
      score_left_q     <= 4'd0;
      score_right_q    <= 4'd0;
      winner_q         <= WIN_NONE;
      serve_dir_q      <= 1'b1;
      paddle_en_q      <= 1'b0;
      ball_en_q        <= 1'b0;
      position_reset_q <= 1'b0;
      start_sync_q     <= 2'b11;
      start_prev_q     <= 1'b1;
`ifdef PONG_PAUSE_EN
      pause_sync_q     <= 2'b11;
      pause_prev_q     <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q          <= state_d;
      frame_cnt_q      <= frame_cnt_d;
      score_left_q     <= score_left_d;
      score_right_q    <= score_right_d;
      winner_q         <= winner_d;
      serve_dir_q      <= serve_dir_d;
      paddle_en_q      <= paddle_en_d;
      ball_en_q        <= ball_en_d;
      position_reset_q <= position_reset_d;
      start_sync_q     <= start_sync_d;
      start_prev_q     <= start_prev_d;
`ifdef PONG_PAUSE_EN
      pause_sync_q     <= pause_sync_d;
      pause_prev_q     <= pause_prev_d;
`endif
    end
  end

  assign state          = state_q;
  assign paddle_en      = paddle_en_q;
  assign ball_en        = ball_en_q;
  assign position_reset = position_reset_q;
  assign serve_dir      = serve_dir_q;
  assign score_left     = score_left_q;
  assign score_right    = score_right_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_pong_game_control.sv
// Directed bench for pong_game_control with SERVE_FRAMES=3, WIN_SCORE=3
// and a free-running frame_tick every 10 cycles. Define PONG_PAUSE_EN to
// also exercise the pause feature.
module tb_pong_game_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_n;
`ifdef PONG_PAUSE_EN
  logic       pause_n;
`endif
  logic       frame_tick;
  logic       miss_left;
  logic       miss_right;
  logic       paddle_en;
  logic       ball_en;
  logic       position_reset;
  logic       serve_dir;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic [1:0] winner;
  logic [2:0] state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pong_game_control #(.SERVE_FRAMES(3), .WIN_SCORE(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_n        (start_n),
`ifdef PONG_PAUSE_EN
    .pause_n        (pause_n),
`endif
    .frame_tick     (frame_tick),
    .miss_left      (miss_left),
    .miss_right     (miss_right),
    .paddle_en      (paddle_en),
    .ball_en        (ball_en),
    .position_reset (position_reset),
    .serve_dir      (serve_dir),
    .score_left     (score_left),
    .score_right    (score_right),
    .winner         (winner),
    .state          (state)
  );

  always #5 clock = ~clock;

  // Frame tick: one clock wide, every 10 cycles, changed 2 time units after
  // a rising edge so it is stable whenever the tests look at it.
  initial begin
    frame_tick = 1'b0;
    forever begin
      repeat (9) @(posedge clock);
      #2 frame_tick = 1'b1;
      @(posedge clock);
      #2 frame_tick = 1'b0;
    end
  end

  // From the first SERVE cycle, wait for PLAY; expect exactly three ticks
  // consumed in SERVE and no further recentre pulse.
  task automatic wait_play(input string name);
    int         ticks;
    int         extra_pr;
    bit         done;
    logic [2:0] st;
    logic       tk;
    ticks = 0; extra_pr = 0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      st = state;
      tk = frame_tick;
      @(negedge clock);
      if (st == 3'd1 && tk) ticks++;
      if (position_reset) extra_pr++;
      if (state == 3'd2) done = 1'b1;
    end
    total_cnt++;
    if (!done) $display("FAIL %s_play_timeout: state=%0d never reached 2", name, state);
    else if (ticks != 3) $display("FAIL %s_serve_ticks: got %0d ticks expected 3", name, ticks);
    else pass_cnt++;
    total_cnt++;
    if ({paddle_en, ball_en, extra_pr} !== {1'b1, 1'b1, 32'd0})
      $display("FAIL %s_play_outputs: paddle=%b ball=%b extra_pr=%0d expected 1 1 0",
               name, paddle_en, ball_en, extra_pr);
    else pass_cnt++;
  endtask

  // Press start from prev_state; checks sync latency, SERVE entry, PLAY entry.
  task automatic press_start(input string name, input logic [2:0] prev_state);
    start_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      total_cnt++;
      if (state !== prev_state)
        $display("FAIL %s_sync_delay: state=%0d expected %0d", name, state, prev_state);
      else pass_cnt++;
    end
    @(negedge clock);
    total_cnt++;
    if ({state, position_reset, paddle_en, ball_en} !== {3'd1, 1'b1, 1'b1, 1'b0})
      $display("FAIL %s_serve_entry: state/pr/pad/ball=%h expected %h", name,
               {state, position_reset, paddle_en, ball_en}, {3'd1, 1'b1, 1'b1, 1'b0});
    else pass_cnt++;
    total_cnt++;
    if ({score_left, score_right, winner} !== 10'd0)
      $display("FAIL %s_scores_clear: sl=%0d sr=%0d win=%b expected 0 0 00",
               name, score_left, score_right, winner);
    else pass_cnt++;
    fork
      begin
        repeat (2) @(negedge clock);
        start_n = 1'b1;
      end
    join_none
    wait_play(name);
  endtask

  // One point from PLAY; miss_l selects which side missed.
  task automatic score_point(input string name, input logic miss_l,
                             input logic [3:0] exp_sl, input logic [3:0] exp_sr,
                             input logic game_over, input logic [1:0] exp_win);
    if (miss_l) miss_left = 1'b1; else miss_right = 1'b1;
    @(negedge clock);
    miss_left = 1'b0; miss_right = 1'b0;
    total_cnt++;
    if ({state, paddle_en, ball_en, score_left, score_right, serve_dir} !==
        {3'd3, 1'b0, 1'b0, exp_sl, exp_sr, ~miss_l})
      $display("FAIL %s_point: state=%0d pad=%b ball=%b sl=%0d sr=%0d dir=%b expected 3 0 0 %0d %0d %b",
               name, state, paddle_en, ball_en, score_left, score_right, serve_dir,
               exp_sl, exp_sr, ~miss_l);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (game_over) begin
      if ({state, winner, paddle_en, ball_en, position_reset} !== {3'd4, exp_win, 3'b000})
        $display("FAIL %s_gameover: state=%0d win=%b pad=%b ball=%b pr=%b expected 4 %b 0 0 0",
                 name, state, winner, paddle_en, ball_en, position_reset, exp_win);
      else pass_cnt++;
    end else begin
      if ({state, position_reset, paddle_en, ball_en} !== {3'd1, 1'b1, 1'b1, 1'b0})
        $display("FAIL %s_reserve: state/pr/pad/ball=%h expected %h", name,
                 {state, position_reset, paddle_en, ball_en}, {3'd1, 1'b1, 1'b1, 1'b0});
      else pass_cnt++;
      wait_play(name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_n = 1'b1; miss_left = 1'b0; miss_right = 1'b0;
`ifdef PONG_PAUSE_EN
    pause_n = 1'b1;
`endif
    repeat (2) @(negedge clock);
    total_cnt++;
    if ({state, paddle_en, ball_en, position_reset, serve_dir, score_left, score_right, winner} !==
        {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'b00})
      $display("FAIL reset_values: got %h expected %h",
               {state, paddle_en, ball_en, position_reset, serve_dir, score_left, score_right, winner},
               {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'b00});
    else pass_cnt++;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total_cnt++;
    if (state !== 3'd0) $display("FAIL idle_hold: state=%0d expected 0", state);
    else pass_cnt++;
  endtask

  task automatic test_start();
    press_start("start", 3'd0);
  endtask

  task automatic test_point();
    score_point("miss_right", 1'b0, 4'd1, 4'd0, 1'b0, 2'b00);
  endtask

  task automatic test_back_to_back();
    miss_left = 1'b1; miss_right = 1'b1;
    @(negedge clock);
    miss_left = 1'b0; miss_right = 1'b0;
    total_cnt++;
    if ({state, position_reset, score_left, score_right, serve_dir} !==
        {3'd1, 1'b1, 4'd1, 4'd0, 1'b1})
      $display("FAIL double_miss: state=%0d pr=%b sl=%0d sr=%0d dir=%b expected 1 1 1 0 1",
               state, position_reset, score_left, score_right, serve_dir);
    else pass_cnt++;
    wait_play("double_miss");
  endtask

  task automatic test_game_over();
    score_point("left1", 1'b1, 4'd1, 4'd1, 1'b0, 2'b00);
    score_point("left2", 1'b1, 4'd1, 4'd2, 1'b0, 2'b00);
    score_point("left3", 1'b1, 4'd1, 4'd3, 1'b1, 2'b10);
    // Misses outside PLAY must not move the saturated score.
    miss_left = 1'b1;
    @(negedge clock);
    miss_left = 1'b0; miss_right = 1'b1;
    @(negedge clock);
    miss_right = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({state, score_left, score_right, winner} !== {3'd4, 4'd1, 4'd3, 2'b10})
      $display("FAIL gameover_hold: state=%0d sl=%0d sr=%0d win=%b expected 4 1 3 10",
               state, score_left, score_right, winner);
    else pass_cnt++;
    press_start("restart", 3'd4);
  endtask

  task automatic test_reset_mid_game();
    score_point("right_a", 1'b0, 4'd1, 4'd0, 1'b0, 2'b00);
    score_point("right_b", 1'b0, 4'd2, 4'd0, 1'b0, 2'b00);
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({state, paddle_en, ball_en, position_reset, serve_dir, score_left, score_right, winner} !==
        {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'b00})
      $display("FAIL async_reset: got %h expected %h",
               {state, paddle_en, ball_en, position_reset, serve_dir, score_left, score_right, winner},
               {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'b00});
    else pass_cnt++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    total_cnt++;
    if ({state, score_left, score_right} !== {3'd0, 4'd0, 4'd0})
      $display("FAIL post_reset_idle: state=%0d sl=%0d sr=%0d expected 0 0 0",
               state, score_left, score_right);
    else pass_cnt++;
    press_start("after_reset", 3'd0);
  endtask

`ifdef PONG_PAUSE_EN
  task automatic test_pause();
    pause_n = 1'b0;
    repeat (3) @(negedge clock);
    total_cnt++;
    if ({state, paddle_en, ball_en} !== {3'd5, 1'b0, 1'b0})
      $display("FAIL pause_enter: state=%0d pad=%b ball=%b expected 5 0 0",
               state, paddle_en, ball_en);
    else pass_cnt++;
    pause_n = 1'b1; miss_left = 1'b1;
    @(negedge clock);
    miss_left = 1'b0;
    repeat (4) @(negedge clock);
    total_cnt++;
    if ({state, score_left, score_right} !== {3'd5, 4'd0, 4'd0})
      $display("FAIL pause_miss: state=%0d sl=%0d sr=%0d expected 5 0 0",
               state, score_left, score_right);
    else pass_cnt++;
    pause_n = 1'b0;
    repeat (3) @(negedge clock);
    pause_n = 1'b1;
    total_cnt++;
    if ({state, ball_en, position_reset, score_left, score_right} !==
        {3'd2, 1'b1, 1'b0, 4'd0, 4'd0})
      $display("FAIL pause_resume: state=%0d ball=%b pr=%b sl=%0d sr=%0d expected 2 1 0 0 0",
               state, ball_en, position_reset, score_left, score_right);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_point();
    test_back_to_back();
    test_game_over();
    test_reset_mid_game();
`ifdef PONG_PAUSE_EN
    test_pause();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pong_game_control.md
PONG_GAME_CONTROL -- requirements
Module: pong_game_control

Interface
REQ-001 Parameter SERVE_FRAMES, default 60: number of frame_tick pulses spent in SERVE before play starts (1..255).
REQ-002 Parameter WIN_SCORE, default 9: score that ends a game (1..15).
REQ-003 clock  input  1  system clock (50 MHz); all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_n  input  1  active-low start push-button, asynchronous to clock.
REQ-006 frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 miss_left / miss_right  input  1 each  one-cycle pulse when the ball passes the left or right paddle.
REQ-008 paddle_en  output  1  enables paddle movement in the paddle datapath.
REQ-009 ball_en  output  1  enables ball movement.
REQ-010 position_reset  output  1  one-cycle pulse that recentres the paddles (Y=240) and the ball.
REQ-011 serve_dir  output  1  initial ball direction: 0 = toward left, 1 = toward right.
REQ-012 score_left / score_right  output  4 each  player scores.
REQ-013 winner  output  2  00 = none, 01 = left, 10 = right.
REQ-014 state  output  3  current FSM state code.

Function
REQ-015 States and codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4 (PAUSED=5 only with PAUSE_EN); all other codes return to IDLE.
REQ-016 start_n passes through a 2-FF synchronizer; a press is a 1->0 edge on the synchronized signal and is acted on at the 3rd rising edge after start_n falls.
REQ-017 IDLE: all enables 0, scores 0, winner 00; start press -> SERVE.
REQ-018 Every entry into SERVE asserts position_reset for exactly one cycle (the first SERVE cycle) and clears the frame counter.
REQ-019 SERVE: paddle_en=1, ball_en=0; frame counter increments on frame_tick; the tick that brings the count to SERVE_FRAMES -> PLAY on the next edge.
REQ-020 PLAY: paddle_en=1, ball_en=1; miss_left -> score_right+1, serve_dir=0, go to POINT; miss_right -> score_left+1, serve_dir=1, go to POINT.
REQ-021 miss_left and miss_right in the same PLAY cycle: no score change, serve_dir unchanged, go directly to SERVE (replay).
REQ-022 Miss pulses outside PLAY are ignored.
REQ-023 POINT lasts one cycle with both enables 0; if either score equals WIN_SCORE -> GAMEOVER, otherwise -> SERVE.
REQ-024 GAMEOVER: both enables 0; winner identifies the side at WIN_SCORE; scores hold; start press clears scores and winner, then -> SERVE.
REQ-025 Scores never exceed WIN_SCORE (no wrap).
REQ-026 enable outputs are registered and take effect in the cycle the state changes.

Reset
REQ-027 Reset forces state=IDLE, paddle_en=0, ball_en=0, position_reset=0, serve_dir=1, scores=0, winner=00, frame counter=0 and synchronizer=11, immediately and regardless of clock.
REQ-028 Reset asserted mid-game discards all scores; after release the block waits in IDLE for a new start press.

Configuration
REQ-029 Macro PONG_PAUSE_EN: when defined, adds input pause_n (active-low, same 2-FF sync and edge detect as start_n); a press in PLAY -> PAUSED (both enables 0, miss pulses ignored, frame counter frozen); a press in PAUSED -> PLAY with no position_reset; reset from PAUSED -> IDLE.
REQ-030 Without PONG_PAUSE_EN: no pause_n port, PAUSED unreachable, code 5 treated as illegal (-> IDLE).

Verification (bench: SERVE_FRAMES=3, WIN_SCORE=3, frame_tick every 10 cycles)
REQ-031 Reset for 2 cycles, start_n held low for 5 cycles -> state 0->1 on 3rd edge, position_reset high for exactly 1 cycle, state=2 after the 3rd frame_tick.
REQ-032 In PLAY, pulse miss_right -> score_left=1, serve_dir=1, state 2->3->1, position_reset pulses once.
REQ-033 miss_left and miss_right pulsed in the same PLAY cycle -> scores unchanged, state 2->1.
REQ-034 Three miss_left points -> score_right=3, state=4, winner=10, paddle_en=0; further misses leave scores at 3; start press -> scores 0, state=1.
REQ-035 Assert reset during PLAY with score_left=2 -> outputs reach reset values asynchronously; state=0 until the next start press.
REQ-036 With PONG_PAUSE_EN: pause press in PLAY -> state=5, enables 0, miss_left ignored; second press -> state=2, scores unchanged.
